alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: NREQ, default 2, number of requesters sharing the ALU (legal range 2..4).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  NREQ  per-requester request valid.
REQ-005 req_ready  output  NREQ  per-requester request accept.
REQ-006 req_op  input  6*NREQ  ALU op for requester i at bits [6i+5:6i].
REQ-007 req_rv1  input  32*NREQ  first operand for requester i at bits [32i+31:32i].
REQ-008 req_rv2  input  32*NREQ  second operand for requester i at bits [32i+31:32i].
REQ-009 rsp_valid  output  1  result valid.
REQ-010 rsp_ready  input  1  result accept.
REQ-011 rsp_id  output  2  index of requester that owns rsp_data.
REQ-012 rsp_data  output  32  ALU result.
REQ-013 alu_op  output  6  op to shared ALU.
REQ-014 alu_rv1  output  32  first operand to shared ALU.
REQ-015 alu_rv2  output  32  second operand to shared ALU.
REQ-016 alu_rvout  input  32  combinational result from shared ALU.

Function
REQ-017 FSM states IDLE, EXEC, RESP; one operation in flight at any time.
REQ-018 IDLE: grant goes to the lowest-index valid requester at or after pointer rr_ptr (modulo NREQ); req_ready asserted only for that requester, combinationally from req_valid; all other req_ready bits 0.
REQ-019 IDLE with no req_valid bit set: stay IDLE, req_ready all 0, rr_ptr unchanged.
REQ-020 Accept (req_valid[i] & req_ready[i]) in IDLE: register op/rv1/rv2 into alu_op/alu_rv1/alu_rv2, record id i, rr_ptr <= (i+1) mod NREQ, go to EXEC.
REQ-021 EXEC (exactly one cycle): alu_* held stable; at end of cycle capture alu_rvout into rsp_data, go to RESP.
REQ-022 RESP: rsp_valid=1, rsp_data/rsp_id stable until rsp_valid & rsp_ready; on handshake go IDLE; req_ready all 0 in EXEC and RESP.
REQ-023 Latency: accept in cycle N -> rsp_valid asserted in cycle N+2; with rsp_ready held 1, next accept no earlier than cycle N+3.
REQ-024 alu_op/alu_rv1/alu_rv2 retain last issued values outside EXEC; op passed through unmodified (no decode in this block).
REQ-025 Requester dropping req_valid before accept has no effect on state; requester not granted waits, no request is lost or reordered per requester.
REQ-026 rr_ptr wraps NREQ-1 -> 0; with all requesters continuously valid, grants rotate 0,1,..,NREQ-1,0.

Reset
REQ-027 rst_n low (any time, incl. mid-EXEC/RESP): state IDLE, rr_ptr 0, rsp_valid 0, rsp_data 0, rsp_id 0, alu_op/alu_rv1/alu_rv2 0, req_ready 0; in-flight operation discarded, no response issued.
REQ-028 First accept possible in the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro ALU_ARB_STATS_EN defined: extra output grant_cnt (16*NREQ), field i counts accepts of requester i, saturates at 16'hFFFF, reset to 0.
REQ-030 Macro ALU_ARB_STATS_EN undefined: grant_cnt port and counters absent; all other behaviour identical.

Verification
REQ-031 Single: req_valid=01, op=ADD, rv1=5, rv2=7, rsp_ready=1 -> accept cycle 0, rsp_valid cycle 2, rsp_data=12, rsp_id=0.
REQ-032 Contention: both valid from reset, r0 SUB 10-3, r1 XOR F0^0F -> r0 granted first (rsp 7, id 0), then r1 (rsp 0x000000FF, id 1).
REQ-033 Fairness: both valid continuously for 6 ops -> rsp_id sequence 0,1,0,1,0,1.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid/rsp_data/rsp_id stable, req_ready=00 throughout, new accept only after handshake.
REQ-035 Reset mid-op: rst_n low during EXEC of SLL 1<<4 -> no response, all outputs 0, next request after reset served by requester 0 first.
REQ-036 With ALU_ARB_STATS_EN: 3 r0 ops and 2 r1 ops -> grant_cnt = {16'd2,16'd3}.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter giving NREQ requesters one-at-a-time access to a shared ALU.
// Define ALU_ARB_STATS_EN to add the grant_cnt output (saturating per-requester accept counters).
module alu_arbiter #(
    parameter int NREQ = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [6*NREQ-1:0]  req_op,
    input  logic [32*NREQ-1:0] req_rv1,
    input  logic [32*NREQ-1:0] req_rv2,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [1:0]         rsp_id,
    output logic [31:0]        rsp_data,
    output logic [5:0]         alu_op,
    output logic [31:0]        alu_rv1,
    output logic [31:0]        alu_rv2,
    input  logic [31:0]        alu_rvout
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [16*NREQ-1:0] grant_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [1:0]  id_q, id_d;
    logic [5:0]  op_q, op_d;
    logic [31:0] rv1_q, rv1_d;
    logic [31:0] rv2_q, rv2_d;
    logic [31:0] data_q, data_d;

    logic        gnt_found;
    logic [1:0]  gnt_idx;
    logic [5:0]  op_sel;
    logic [31:0] rv1_sel, rv2_sel;
    logic        accept;

    // Descending scans keep the lowest hit: first among indices >= rr_ptr, else wrap to the lowest overall.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (i >= int'(rr_ptr_q))) begin
                gnt_found = 1'b1;
                gnt_idx   = 2'(i);
            end
        end
        if (!gnt_found) begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (req_valid[i]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = 2'(i);
                end
            end
        end
    end

    always_comb begin
        op_sel  = '0;
        rv1_sel = '0;
        rv2_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (int'(gnt_idx) == i) begin
                op_sel  = req_op[6*i +: 6];
                rv1_sel = req_rv1[32*i +: 32];
                rv2_sel = req_rv2[32*i +: 32];
            end
        end
    end

    assign accept = (state_q == S_IDLE) && gnt_found;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = rst_n && accept && (int'(gnt_idx) == i);
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        op_d     = op_q;
        rv1_d    = rv1_q;
        rv2_d    = rv2_q;
        data_d   = data_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d     = op_sel;
                    rv1_d    = rv1_sel;
                    rv2_d    = rv2_sel;
                    id_d     = gnt_idx;
                    rr_ptr_d = (int'(gnt_idx) == NREQ - 1) ? 2'd0 : gnt_idx + 2'd1;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                data_d  = alu_rvout;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            op_q     <= '0;
            rv1_q    <= '0;
            rv2_q    <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            op_q     <= op_d;
            rv1_q    <= rv1_d;
            rv2_q    <= rv2_d;
            data_q   <= data_d;
        end
    end

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign alu_op    = op_q;
    assign alu_rv1   = rv1_q;
    assign alu_rv2   = rv2_q;

`ifdef ALU_ARB_STATS_EN
    for (genvar g = 0; g < NREQ; g++) begin : g_stats
        logic [15:0] cnt_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (accept && (int'(gnt_idx) == g) && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
        assign grant_cnt[16*g +: 16] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus randomized traffic, checked by a cycle model and a response scoreboard.
module tb_alu_arbiter;
    localparam int N = 2;
    localparam logic [5:0] OP_ADD = 6'd0, OP_SUB = 6'd1, OP_XOR = 6'd2, OP_SLL = 6'd3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [6*N-1:0]  req_op = '0;
    logic [32*N-1:0] req_rv1 = '0;
    logic [32*N-1:0] req_rv2 = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [1:0]      rsp_id;
    logic [31:0]     rsp_data;
    logic [5:0]      alu_op;
    logic [31:0]     alu_rv1, alu_rv2, alu_rvout;
`ifdef ALU_ARB_STATS_EN
    logic [16*N-1:0] grant_cnt;
`endif

    always #5 clk = ~clk;

    // Stand-in for the shared ALU that sits outside the arbiter.
    function automatic logic [31:0] alu_ref(logic [5:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            6'd0: return a + b;
            6'd1: return a - b;
            6'd2: return a ^ b;
            6'd3: return a << b[4:0];
            6'd4: return a | b;
            6'd5: return a & b;
            default: return a + {26'd0, op};
        endcase
    endfunction

    assign alu_rvout = alu_ref(alu_op, alu_rv1, alu_rv2);

    alu_arbiter #(.NREQ(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rv1(req_rv1), .req_rv2(req_rv2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data),
        .alu_op(alu_op), .alu_rv1(alu_rv1), .alu_rv2(alu_rv2),
        .alu_rvout(alu_rvout)
`ifdef ALU_ARB_STATS_EN
        , .grant_cnt(grant_cnt)
`endif
    );

    typedef struct packed { logic [5:0] op; logic [31:0] a; logic [31:0] b; } op_t;
    typedef struct packed { logic [1:0] id; logic [31:0] data; } rsp_t;

    op_t  pbuf [N][256];
    int   hd [N];
    int   tl [N];
    int   gcnt [N];
    rsp_t sb[$];
    logic [1:0] idlog[$];
    int   n_tests = 0, n_fail = 0;
    int   stg = 0;  // 0 waiting for a grant, 1 operation executing, 2 response offered
    int   ptr = 0;
    int   rr_pct = 100, gap_pct = 0;
    op_t  last_alu = '0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(int i, logic [5:0] op, logic [31:0] a, logic [31:0] b);
        op_t o;
        o.op = op; o.a = a; o.b = b;
        pbuf[i][tl[i]] = o;
        tl[i]++;
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (hd[i] < tl[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive();
        op_t o;
        for (int i = 0; i < N; i++) begin
            if (hd[i] < tl[i] && (gap_pct == 0 || $urandom_range(0, 99) >= gap_pct)) begin
                o = pbuf[i][hd[i]];
                req_valid[i] = 1'b1;
                req_op[6*i +: 6]   = o.op;
                req_rv1[32*i +: 32] = o.a;
                req_rv2[32*i +: 32] = o.b;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
        rsp_ready = ($urandom_range(0, 99) < rr_pct);
    endtask

    // One clock of the reference model: check at the negedge, then advance model and stimulus.
    task automatic cyc();
        logic [N-1:0] er;
        int g, j;
        op_t o;
        rsp_t r;
        @(negedge clk);
        er = '0;
        g = -1;
        if (stg == 0) begin
            for (int k = 0; k < N; k++) begin
                j = (ptr + k) % N;
                if (g < 0 && req_valid[j]) g = j;
            end
            if (g >= 0) er[g] = 1'b1;
        end
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("rsp_valid", 64'(rsp_valid), 64'(stg == 2));
        chk("alu_op", 64'(alu_op), 64'(last_alu.op));
        chk("alu_rv1", 64'(alu_rv1), 64'(last_alu.a));
        chk("alu_rv2", 64'(alu_rv2), 64'(last_alu.b));
        case (stg)
            0: if (g >= 0) begin
                o = pbuf[g][hd[g]];
                r.id = 2'(g);
                r.data = alu_ref(o.op, o.a, o.b);
                sb.push_back(r);
                last_alu = o;
                hd[g]++;
                gcnt[g]++;
                ptr = (g + 1) % N;
                stg = 1;
            end
            1: stg = 2;
            default: if (rsp_ready) stg = 0;
        endcase
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_done(int budget);
        int c;
        c = 0;
        while ((pending() || stg != 0) && c < budget) begin
            cyc();
            c++;
        end
        chk("run_budget", 64'(c < budget), 64'd1);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        req_valid = '1;
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_alu_op", 64'(alu_op), 64'd0);
        chk("rst_alu_rv1", 64'(alu_rv1), 64'd0);
        chk("rst_alu_rv2", 64'(alu_rv2), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        stg = 0;
        ptr = 0;
        last_alu = '0;
        sb.delete();
        for (int i = 0; i < N; i++) gcnt[i] = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drive();
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                chk("rsp_id", 64'(rsp_id), 64'(sb[0].id));
                chk("rsp_data", 64'(rsp_data), 64'(sb[0].data));
                if (rsp_ready) begin
                    idlog.push_back(rsp_id);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin hd[i] = 0; tl[i] = 0; gcnt[i] = 0; end

        // Single ADD straight out of reset
        add(0, OP_ADD, 32'd5, 32'd7);
        do_reset();
        idlog.delete();
        run_done(50);
        chk("single_cnt", 64'(idlog.size()), 64'd1);
        chk("single_id", 64'(idlog[0]), 64'd0);

        // Contention from reset: r0 wins first
        add(0, OP_SUB, 32'd10, 32'd3);
        add(1, OP_XOR, 32'hF0, 32'h0F);
        do_reset();
        idlog.delete();
        run_done(50);
        chk("cont_cnt", 64'(idlog.size()), 64'd2);
        chk("cont_id0", 64'(idlog[0]), 64'd0);
        chk("cont_id1", 64'(idlog[1]), 64'd1);

        // Fairness: both continuously valid
        idlog.delete();
        for (int k = 0; k < 3; k++) begin
            add(0, 6'($urandom_range(0, 7)), $urandom, $urandom);
            add(1, 6'($urandom_range(0, 7)), $urandom, $urandom);
        end
        drive();
        run_done(100);
        chk("fair_cnt", 64'(idlog.size()), 64'd6);
        for (int k = 0; k < idlog.size(); k++) chk("fair_id", 64'(idlog[k]), 64'(k % 2));

        // Backpressure: hold rsp_ready low across the response
        add(0, OP_ADD, 32'h1234, 32'h1111);
        add(1, OP_SUB, 32'h0, 32'h1);
        rr_pct = 0;
        drive();
        repeat (8) cyc();
        chk("bp_stalled", 64'(stg), 64'd2);
        rr_pct = 100;
        run_done(50);

        // Reset while SLL is executing: it must vanish, r0 first afterwards
        idlog.delete();
        add(0, OP_SLL, 32'd1, 32'd4);
        drive();
        cyc();
        chk("sll_accepted", 64'(stg), 64'd1);
        do_reset();
        repeat (3) cyc();
        chk("rst_no_rsp", 64'(idlog.size()), 64'd0);
        add(1, OP_ADD, 32'd1, 32'd1);
        add(0, OP_ADD, 32'd2, 32'd2);
        drive();
        run_done(50);
        chk("post_rst_first", 64'(idlog[0]), 64'd0);

        // Randomized traffic with valid gaps and random backpressure
        gap_pct = 30;
        rr_pct = 70;
        for (int k = 0; k < 200; k++) begin
            add($urandom_range(0, N - 1), 6'($urandom_range(0, 7)), $urandom, $urandom);
        end
        run_done(5000);
        chk("sb_drained", 64'(sb.size()), 64'd0);

`ifdef ALU_ARB_STATS_EN
        for (int i = 0; i < N; i++) chk("grant_cnt_rand", 64'(grant_cnt[16*i +: 16]), 64'(gcnt[i]));
        gap_pct = 0;
        rr_pct = 100;
        for (int k = 0; k < 3; k++) add(0, OP_ADD, 32'(k), 32'd1);
        for (int k = 0; k < 2; k++) add(1, OP_XOR, 32'(k), 32'd3);
        do_reset();
        run_done(100);
        chk("grant_cnt", 64'(grant_cnt), {32'd0, 16'd2, 16'd3});
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
